// File: rtl/mem_wb_stage.sv
// MEM stage: word-addressed data memory with a two-cycle load, branch resolve,
// sticky access-error flag and the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int DEPTH = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] AddResult,
  input  logic        Zero,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [4:0]  WriteReg,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        Stall,
  output logic        OutRegWrite,
  output logic        OutMemtoReg,
  output logic [31:0] OutReadData,
  output logic [31:0] OutALUResult,
  output logic [4:0]  OutWriteReg,
  output logic        AccessErr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   read_reg;
  logic [AW-1:0] addr;
  logic          bad_access, good_read, good_write;
  logic          set_err;
  logic          nxt_reg_write, nxt_memto_reg;
  logic [31:0]   nxt_read_data, nxt_alu_result;
  logic [4:0]    nxt_write_reg;

  // Address bits above the memory depth are ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ALUResult[31:AW+2];

  assign PCSrc        = Branch & Zero;
  assign BranchTarget = AddResult;
  assign addr         = ALUResult[AW+1:2];
  assign bad_access   = ((MemRead | MemWrite) && (ALUResult[1:0] != 2'b00))
                      || (MemRead && MemWrite);
  assign good_read    = MemRead && !bad_access;
  assign good_write   = MemWrite && !bad_access;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    Stall          = 1'b0;
    set_err        = 1'b0;
    nxt_reg_write  = RegWrite;
    nxt_memto_reg  = MemtoReg;
    nxt_read_data  = 32'h0;
    nxt_alu_result = ALUResult;
    nxt_write_reg  = WriteReg;
    case (state)
      IDLE: begin
        if (bad_access) begin
          set_err       = 1'b1;
          nxt_reg_write = 1'b0;
        end else if (good_read) begin
          // First load cycle inserts a bubble while the word is fetched.
          Stall          = 1'b1;
          state_next     = LOAD_WAIT;
          nxt_reg_write  = 1'b0;
          nxt_memto_reg  = 1'b0;
          nxt_alu_result = 32'h0;
          nxt_write_reg  = 5'd0;
        end
      end
      LOAD_WAIT: begin
        nxt_read_data = read_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      read_reg <= 32'h0;
    end else if (state == IDLE) begin
      if (good_write) mem[addr] <= WriteData;
      if (good_read)  read_reg  <= mem[addr];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OutRegWrite  <= 1'b0;
      OutMemtoReg  <= 1'b0;
      OutReadData  <= 32'h0;
      OutALUResult <= 32'h0;
      OutWriteReg  <= 5'd0;
      AccessErr    <= 1'b0;
    end else begin
      OutRegWrite  <= nxt_reg_write;
      OutMemtoReg  <= nxt_memto_reg;
      OutReadData  <= nxt_read_data;
      OutALUResult <= nxt_alu_result;
      OutWriteReg  <= nxt_write_reg;
      if (set_err) AccessErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected MEM/WB contents are queued as
// stimulus is driven and popped after each rising edge.
module tb_mem_wb_stage;

  localparam int DEPTH = 64;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        RegWrite, MemtoReg, Branch, MemRead, MemWrite, Zero;
  logic [31:0] AddResult, ALUResult, WriteData;
  logic [4:0]  WriteReg;
  logic        PCSrc, Stall, OutRegWrite, OutMemtoReg, AccessErr;
  logic [31:0] BranchTarget, OutReadData, OutALUResult;
  logic [4:0]  OutWriteReg;

  mem_wb_stage #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .AddResult(AddResult), .Zero(Zero), .ALUResult(ALUResult),
    .WriteData(WriteData), .WriteReg(WriteReg),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Stall(Stall),
    .OutRegWrite(OutRegWrite), .OutMemtoReg(OutMemtoReg),
    .OutReadData(OutReadData), .OutALUResult(OutALUResult),
    .OutWriteReg(OutWriteReg), .AccessErr(AccessErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic rw; logic mtr; logic [31:0] rd; logic [31:0] alu; logic [4:0] wr;
  } mwb_t;

  typedef struct packed {
    logic rw; logic mtr; logic br; logic mr; logic mw;
    logic [31:0] add; logic z; logic [31:0] alu; logic [31:0] wd; logic [4:0] wr;
  } stim_t;

  typedef struct packed {
    stim_t s; mwb_t e; logic st;
  } cyc_t;

  mwb_t        exp_q[$];
  logic [31:0] mem_model [DEPTH];
  int          n_compared = 0;
  int          n_mismatched = 0;

  function automatic stim_t st(input logic rw, mtr, br, mr, mw, input logic [31:0] add,
                               input logic z, input logic [31:0] alu, wd, input logic [4:0] wr);
    stim_t s;
    s.rw = rw; s.mtr = mtr; s.br = br; s.mr = mr; s.mw = mw;
    s.add = add; s.z = z; s.alu = alu; s.wd = wd; s.wr = wr;
    return s;
  endfunction

  function automatic mwb_t ex(input logic rw, mtr, input logic [31:0] rd, alu, input logic [4:0] wr);
    mwb_t e;
    e.rw = rw; e.mtr = mtr; e.rd = rd; e.alu = alu; e.wr = wr;
    return e;
  endfunction

  function automatic cyc_t cy(input stim_t s, input mwb_t e, input logic stall);
    cyc_t c;
    c.s = s; c.e = e; c.st = stall;
    return c;
  endfunction

  function automatic mwb_t observed();
    return {OutRegWrite, OutMemtoReg, OutReadData, OutALUResult, OutWriteReg};
  endfunction

  task automatic set_inputs(input stim_t s);
    RegWrite = s.rw; MemtoReg = s.mtr; Branch = s.br; MemRead = s.mr; MemWrite = s.mw;
    AddResult = s.add; Zero = s.z; ALUResult = s.alu; WriteData = s.wd; WriteReg = s.wr;
  endtask

  task automatic drive(input stim_t s);
    @(negedge Clk);
    set_inputs(s);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    set_inputs(st(0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    #12;
    n_compared++;
    if (observed() !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outs: got %h want 0", observed());
    end
    n_compared++;
    if (AccessErr !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_err: got %b want 0", AccessErr);
    end
    n_compared++;
    if (Stall !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_stall_idle: got %b want 1", Stall);
    end
    set_inputs(st(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    cyc_t cyc[$];
    mwb_t got, want;
    cyc.push_back(cy(st(0, 0, 0, 0, 1, 0, 0, 32'h8, 32'hDEADBEEF, 0), ex(0, 0, 0, 32'h8, 0), 1'b0));
    cyc.push_back(cy(st(1, 1, 0, 1, 0, 0, 0, 32'h8, 0, 5), ex(0, 0, 0, 0, 0), 1'b1));
    cyc.push_back(cy(st(1, 1, 0, 1, 0, 0, 0, 32'h8, 0, 5), ex(1, 1, 32'hDEADBEEF, 32'h8, 5), 1'b0));
    mem_model[2] = 32'hDEADBEEF;
    foreach (cyc[i]) begin
      drive(cyc[i].s);
      exp_q.push_back(cyc[i].e);
      #1;
      n_compared++;
      if (Stall !== cyc[i].st) begin
        n_mismatched++;
        $display("[TB] FAIL store_load_stall cyc %0d: got %b want %b", i, Stall, cyc[i].st);
      end
      @(posedge Clk); #1;
      want = exp_q.pop_front();
      got = observed();
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL store_load_out cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    cyc_t cyc[$];
    mwb_t got, want;
    cyc.push_back(cy(st(0, 0, 0, 0, 1, 0, 0, 32'h100, 32'h1234, 0), ex(0, 0, 0, 32'h100, 0), 1'b0));
    cyc.push_back(cy(st(1, 0, 0, 1, 0, 0, 0, 32'h0, 0, 7), ex(0, 0, 0, 0, 0), 1'b1));
    cyc.push_back(cy(st(1, 0, 0, 1, 0, 0, 0, 32'h0, 0, 7), ex(1, 0, 32'h1234, 32'h0, 7), 1'b0));
    mem_model[0] = 32'h1234;
    foreach (cyc[i]) begin
      drive(cyc[i].s);
      exp_q.push_back(cyc[i].e);
      #1;
      n_compared++;
      if (Stall !== cyc[i].st) begin
        n_mismatched++;
        $display("[TB] FAIL wrap_stall cyc %0d: got %b want %b", i, Stall, cyc[i].st);
      end
      @(posedge Clk); #1;
      want = exp_q.pop_front();
      got = observed();
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL wrap_out cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    mwb_t got, want;
    drive(st(0, 0, 1, 0, 0, 32'h40, 1, 32'h0, 0, 0));
    exp_q.push_back(ex(0, 0, 0, 32'h0, 0));
    #1;
    n_compared++;
    if (PCSrc !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL branch_taken_pcsrc: got %b want 1", PCSrc);
    end
    n_compared++;
    if (BranchTarget !== 32'h40) begin
      n_mismatched++;
      $display("[TB] FAIL branch_target: got %h want 00000040", BranchTarget);
    end
    @(posedge Clk); #1;
    want = exp_q.pop_front();
    got = observed();
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL branch_out: got %h want %h", got, want);
    end
    drive(st(0, 0, 1, 0, 0, 32'h40, 0, 32'h0, 0, 0));
    #1;
    n_compared++;
    if (PCSrc !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL branch_not_taken_pcsrc: got %b want 0", PCSrc);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t        cyc[$];
    mwb_t        got, want;
    stim_t       s;
    int          kind, idx;
    logic        rw, mtr;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      idx  = $urandom_range(0, DEPTH - 1);
      rw   = 1'($urandom_range(0, 1));
      mtr  = 1'($urandom_range(0, 1));
      wr   = 5'($urandom_range(0, 31));
      wd   = $urandom();
      alu  = ($urandom() & 32'hFFFF_FF00) | (32'(idx) << 2);
      if (kind == 0) begin
        alu = $urandom();
        cyc.push_back(cy(st(rw, mtr, 0, 0, 0, 0, 0, alu, wd, wr), ex(rw, mtr, 0, alu, wr), 1'b0));
      end else if (kind == 1) begin
        cyc.push_back(cy(st(rw, mtr, 0, 0, 1, 0, 0, alu, wd, wr), ex(rw, mtr, 0, alu, wr), 1'b0));
        mem_model[idx] = wd;
      end else begin
        s = st(rw, mtr, 0, 1, 0, 0, 0, alu, wd, wr);
        cyc.push_back(cy(s, ex(0, 0, 0, 0, 0), 1'b1));
        cyc.push_back(cy(s, ex(rw, mtr, mem_model[idx], alu, wr), 1'b0));
      end
    end
    foreach (cyc[i]) begin
      drive(cyc[i].s);
      exp_q.push_back(cyc[i].e);
      #1;
      n_compared++;
      if (Stall !== cyc[i].st) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_stall cyc %0d: got %b want %b", i, Stall, cyc[i].st);
      end
      @(posedge Clk); #1;
      want = exp_q.pop_front();
      got = observed();
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_out cyc %0d: got %h want %h", i, got, want);
      end
    end
    n_compared++;
    if (AccessErr !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_no_err: got %b want 0", AccessErr);
    end
  endtask

  task automatic test_misaligned();
    cyc_t cyc[$];
    mwb_t got, want;
    cyc.push_back(cy(st(0, 0, 0, 0, 1, 0, 0, 32'h4, 32'h11111111, 0), ex(0, 0, 0, 32'h4, 0), 1'b0));
    cyc.push_back(cy(st(1, 0, 0, 0, 1, 0, 0, 32'h6, 32'hFFFFFFFF, 3), ex(0, 0, 0, 32'h6, 3), 1'b0));
    cyc.push_back(cy(st(1, 1, 0, 1, 1, 0, 0, 32'h4, 32'h0BAD, 2), ex(0, 1, 0, 32'h4, 2), 1'b0));
    cyc.push_back(cy(st(1, 0, 0, 1, 0, 0, 0, 32'h4, 0, 9), ex(0, 0, 0, 0, 0), 1'b1));
    cyc.push_back(cy(st(1, 0, 0, 1, 0, 0, 0, 32'h4, 0, 9), ex(1, 0, 32'h11111111, 32'h4, 9), 1'b0));
    for (int n = 0; n < 10; n++)
      cyc.push_back(cy(st(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0), ex(0, 0, 0, 0, 0), 1'b0));
    mem_model[1] = 32'h11111111;
    foreach (cyc[i]) begin
      drive(cyc[i].s);
      exp_q.push_back(cyc[i].e);
      #1;
      n_compared++;
      if (Stall !== cyc[i].st) begin
        n_mismatched++;
        $display("[TB] FAIL misaligned_stall cyc %0d: got %b want %b", i, Stall, cyc[i].st);
      end
      @(posedge Clk); #1;
      want = exp_q.pop_front();
      got = observed();
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL misaligned_out cyc %0d: got %h want %h", i, got, want);
      end
      if (i < 2) begin
        n_compared++;
        if (AccessErr !== (i == 1)) begin
          n_mismatched++;
          $display("[TB] FAIL misaligned_err cyc %0d: got %b want %b", i, AccessErr, (i == 1));
        end
      end
    end
    n_compared++;
    if (AccessErr !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL misaligned_err_sticky: got %b want 1", AccessErr);
    end
  endtask

  task automatic test_reset_mid_load();
    cyc_t cyc[$];
    mwb_t got, want;
    drive(st(1, 0, 0, 1, 0, 0, 0, 32'h8, 0, 5));
    #1;
    n_compared++;
    if (Stall !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midload_issue_stall: got %b want 1", Stall);
    end
    @(posedge Clk); #1;
    #2 Rst_n = 1'b0;
    #1;
    n_compared++;
    if (observed() !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL midload_outs: got %h want 0", observed());
    end
    n_compared++;
    if (AccessErr !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midload_err: got %b want 0", AccessErr);
    end
    n_compared++;
    if (Stall !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midload_idle_stall: got %b want 1", Stall);
    end
    @(posedge Clk); #1;
    n_compared++;
    if (observed() !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL midload_no_update: got %h want 0", observed());
    end
    set_inputs(st(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    cyc.push_back(cy(st(1, 0, 0, 1, 0, 0, 0, 32'h8, 0, 5), ex(0, 0, 0, 0, 0), 1'b1));
    cyc.push_back(cy(st(1, 0, 0, 1, 0, 0, 0, 32'h8, 0, 5), ex(1, 0, mem_model[2], 32'h8, 5), 1'b0));
    foreach (cyc[i]) begin
      drive(cyc[i].s);
      exp_q.push_back(cyc[i].e);
      #1;
      n_compared++;
      if (Stall !== cyc[i].st) begin
        n_mismatched++;
        $display("[TB] FAIL midload_reload_stall cyc %0d: got %b want %b", i, Stall, cyc[i].st);
      end
      @(posedge Clk); #1;
      want = exp_q.pop_front();
      got = observed();
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL midload_reload_out cyc %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_branch();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
